// File: rtl/lfsr_search_ctrl.sv
// Sequences a shared 17-bit LFSR through a polynomial table to locate a captured bit window.
// Optional LFSR_SEARCH_ABORT_EN adds an 'abort' input that ends a LOAD/RUN search as not-found.
module lfsr_search_ctrl #(
   parameter int NUM_POLY = 2,
   parameter int MAX_ITER = 131071,
   parameter int IDX_W    = 5
) (
   input  logic                   clk_96MHz,
   input  logic                   reset,
   input  logic [17*NUM_POLY-1:0] poly_table,
   input  logic [16:0]            start_data,
`ifdef LFSR_SEARCH_ABORT_EN
   input  logic                   abort,
`endif
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [16:0]            req_target,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   res_found,
   output logic [IDX_W-1:0]       res_poly_idx,
   output logic [16:0]            res_iter,
   output logic [16:0]            lfsr_polynomial,
   output logic [16:0]            lfsr_start_data,
   output logic                   lfsr_enable,
   input  logic [16:0]            lfsr_value,
   input  logic [16:0]            lfsr_iter
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [16:0]       run_cnt_reg, run_cnt_next;
   logic [16:0]       target_reg, target_next;
   logic              found_reg, found_next;
   logic [IDX_W-1:0]  poly_idx_reg, poly_idx_next;
   logic [16:0]       iter_reg, iter_next;
   logic              abort_hit;

   // Table padded to the full index range so any idx value selects a defined entry.
   logic [16:0] poly_arr [2**IDX_W];
   generate
      for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_poly
         if (gi < NUM_POLY) begin : g_used
            assign poly_arr[gi] = poly_table[17*gi +: 17];
         end else begin : g_pad
            assign poly_arr[gi] = '0;
         end
      end
   endgenerate

`ifdef LFSR_SEARCH_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign lfsr_polynomial = poly_arr[idx_reg];
   assign lfsr_start_data = start_data;
   assign lfsr_enable     = (state_reg == RUN);
   assign req_ready       = (state_reg == IDLE);
   assign res_valid       = (state_reg == DONE);
   assign res_found       = found_reg;
   assign res_poly_idx    = poly_idx_reg;
   assign res_iter        = iter_reg;

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         run_cnt_reg  <= '0;
         target_reg   <= '0;
         found_reg    <= 1'b0;
         poly_idx_reg <= '0;
         iter_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         run_cnt_reg  <= run_cnt_next;
         target_reg   <= target_next;
         found_reg    <= found_next;
         poly_idx_reg <= poly_idx_next;
         iter_reg     <= iter_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      run_cnt_next  = run_cnt_reg;
      target_next   = target_reg;
      found_next    = found_reg;
      poly_idx_next = poly_idx_reg;
      iter_next     = iter_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               target_next = req_target;
               idx_next    = '0;
               // The LFSR never produces zero, so a zero target cannot match.
               if (req_target == 17'd0) begin
                  state_next    = DONE;
                  found_next    = 1'b0;
                  poly_idx_next = '0;
                  iter_next     = '0;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            run_cnt_next = '0;
            if (abort_hit) begin
               state_next    = DONE;
               found_next    = 1'b0;
               poly_idx_next = '0;
               iter_next     = '0;
            end else begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (abort_hit) begin
               state_next    = DONE;
               found_next    = 1'b0;
               poly_idx_next = '0;
               iter_next     = '0;
            end else if (lfsr_value == target_reg) begin
               state_next    = DONE;
               found_next    = 1'b1;
               poly_idx_next = idx_reg;
               iter_next     = lfsr_iter;
            end else if (run_cnt_reg == 17'(MAX_ITER - 1)) begin
               if (idx_reg == IDX_W'(NUM_POLY - 1)) begin
                  state_next    = DONE;
                  found_next    = 1'b0;
                  poly_idx_next = '0;
                  iter_next     = '0;
               end else begin
                  idx_next   = idx_reg + IDX_W'(1);
                  state_next = LOAD;
               end
            end else begin
               run_cnt_next = run_cnt_reg + 17'd1;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lfsr_search_ctrl.sv
// Directed bench for lfsr_search_ctrl with a behavioural 17-bit LFSR attached to its LFSR port.
// Builds with or without LFSR_SEARCH_ABORT_EN; the abort scenario runs only when it is defined.
module tb_lfsr_search_ctrl;
   localparam int NUM_POLY = 2;
   localparam int MAX_ITER = 1200;
   localparam int IDX_W    = 5;
   localparam logic [16:0] POLY0 = 17'h1d258;
   localparam logic [16:0] POLY1 = 17'h17e04;
   localparam logic [16:0] START = 17'h00001;

   logic clk_96MHz = 1'b0;
   always #5 clk_96MHz = ~clk_96MHz;

   logic                   reset;
   logic [17*NUM_POLY-1:0] poly_table;
   logic [16:0]            start_data;
   logic                   req_valid;
   logic                   req_ready;
   logic [16:0]            req_target;
   logic                   res_valid;
   logic                   res_ready;
   logic                   res_found;
   logic [IDX_W-1:0]       res_poly_idx;
   logic [16:0]            res_iter;
   logic [16:0]            lfsr_polynomial;
   logic [16:0]            lfsr_start_data;
   logic                   lfsr_enable;
   logic [16:0]            lfsr_value;
   logic [16:0]            lfsr_iter;
`ifdef LFSR_SEARCH_ABORT_EN
   logic                   abort;
`endif

   int n_checks = 0;
   int n_errors = 0;

   lfsr_search_ctrl #(
      .NUM_POLY(NUM_POLY),
      .MAX_ITER(MAX_ITER),
      .IDX_W   (IDX_W)
   ) dut (
      .clk_96MHz      (clk_96MHz),
      .reset          (reset),
      .poly_table     (poly_table),
      .start_data     (start_data),
`ifdef LFSR_SEARCH_ABORT_EN
      .abort          (abort),
`endif
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_target     (req_target),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_found      (res_found),
      .res_poly_idx   (res_poly_idx),
      .res_iter       (res_iter),
      .lfsr_polynomial(lfsr_polynomial),
      .lfsr_start_data(lfsr_start_data),
      .lfsr_enable    (lfsr_enable),
      .lfsr_value     (lfsr_value),
      .lfsr_iter      (lfsr_iter)
   );

   function automatic logic [16:0] lfsr_step(input logic [16:0] v, input logic [16:0] p);
      return {v[15:0], ^(v & p)};
   endfunction

   function automatic logic [16:0] poly_of(input int p);
      return (p == 0) ? POLY0 : POLY1;
   endfunction

   function automatic logic [16:0] lfsr_at(input logic [16:0] p, input int n);
      logic [16:0] v;
      v = START;
      for (int k = 0; k < n; k++) v = lfsr_step(v, p);
      return v;
   endfunction

   // The external LFSR block the controller drives.
   always_ff @(posedge clk_96MHz) begin
      if (!lfsr_enable) begin
         lfsr_value <= lfsr_start_data;
         lfsr_iter  <= 17'd0;
      end else begin
         lfsr_value <= lfsr_step(lfsr_value, lfsr_polynomial);
         lfsr_iter  <= lfsr_iter + 17'd1;
      end
   end

   // Reference search: lat counts edges from the accept edge to the first cycle with res_valid.
   task automatic model_search(input logic [16:0] t, output logic f, output int idx,
                               output int it, output int lat);
      logic [16:0] v;
      f   = 1'b0;
      idx = 0;
      it  = 0;
      lat = NUM_POLY * (MAX_ITER + 1);
      if (t == 17'd0) begin
         lat = 0;
         return;
      end
      for (int p = 0; p < NUM_POLY; p++) begin
         v = START;
         for (int k = 0; k < MAX_ITER; k++) begin
            if (v == t) begin
               f   = 1'b1;
               idx = p;
               it  = k;
               lat = p * (MAX_ITER + 1) + k + 2;
               return;
            end
            v = lfsr_step(v, poly_of(p));
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input string tag, input logic [16:0] t, input logic ef,
                          input int eidx, input int eit, input int elat, input bit consume);
      int cycles;
      check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_target = t;
      @(posedge clk_96MHz);
      #1;
      req_valid = 1'b0;
      check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      cycles = 0;
      while (res_valid !== 1'b1 && cycles < 5000) begin
         @(posedge clk_96MHz);
         #1;
         cycles++;
      end
      check({tag, "_latency"}, 32'(cycles), 32'(elat));
      check({tag, "_found"}, 32'(res_found), 32'(ef));
      check({tag, "_idx"}, 32'(res_poly_idx), 32'(eidx));
      check({tag, "_iter"}, 32'(res_iter), 32'(eit));
      check({tag, "_enable_done"}, 32'(lfsr_enable), 32'd0);
      $display("txn %s target=%05h found=%0d idx=%0d iter=%0d latency=%0d", tag, t,
               res_found, res_poly_idx, res_iter, cycles);
      if (consume) begin
         res_ready = 1'b1;
         @(posedge clk_96MHz);
         #1;
         res_ready = 1'b0;
         check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
         check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
      end
   endtask

   initial begin
      logic        ef;
      int          eidx, eit, elat;
      logic [16:0] t, t_miss;
      logic [16:0] hold_iter;
      logic [IDX_W-1:0] hold_idx;

      reset      = 1'b1;
      poly_table = {POLY1, POLY0};
      start_data = START;
      req_valid  = 1'b0;
      req_target = '0;
      res_ready  = 1'b0;
`ifdef LFSR_SEARCH_ABORT_EN
      abort      = 1'b0;
`endif
      repeat (3) @(posedge clk_96MHz);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_found", 32'(res_found), 32'd0);
      check("rst_res_idx", 32'(res_poly_idx), 32'd0);
      check("rst_res_iter", 32'(res_iter), 32'd0);
      check("rst_enable", 32'(lfsr_enable), 32'd0);
      check("rst_poly", 32'(lfsr_polynomial), 32'(POLY0));
      check("rst_start", 32'(lfsr_start_data), 32'(START));
      reset = 1'b0;
      @(posedge clk_96MHz);
      #1;

      // T1: target equals the seed, matched on the first RUN cycle.
      run_req("T1", 17'h00001, 1'b1, 0, 0, 2, 1'b1);

      // T2: value of the second polynomial at iteration 1000.
      t = lfsr_at(POLY1, 1000);
      model_search(t, ef, eidx, eit, elat);
      run_req("T2", t, ef, eidx, eit, elat, 1'b0);
      hold_idx  = res_poly_idx;
      hold_iter = res_iter;
      res_ready = 1'b1;
      @(posedge clk_96MHz);
      #1;
      res_ready = 1'b0;
      check("T2_valid_drop", 32'(res_valid), 32'd0);
      check("T2_idle_keeps_idx", 32'(res_poly_idx), 32'(hold_idx));
      check("T2_idle_keeps_iter", 32'(res_iter), 32'(hold_iter));

      // T4: zero target completes on the accept edge and clears the earlier result.
      run_req("T4", 17'h00000, 1'b0, 0, 0, 0, 1'b0);
      req_valid  = 1'b1;
      req_target = 17'h00001;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_96MHz);
         #1;
         check("T4_hold_valid", 32'(res_valid), 32'd1);
         check("T4_hold_found", 32'(res_found), 32'd0);
         check("T4_hold_iter", 32'(res_iter), 32'd0);
         check("T4_hold_ready", 32'(req_ready), 32'd0);
         check("T4_hold_enable", 32'(lfsr_enable), 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk_96MHz);
      #1;
      res_ready = 1'b0;
      check("T4_release_valid", 32'(res_valid), 32'd0);
      check("T4_release_ready", 32'(req_ready), 32'd1);
      run_req("T4b", 17'h00001, 1'b1, 0, 0, 2, 1'b1);

      // Last iteration of the first table entry is still searched.
      t = lfsr_at(POLY0, MAX_ITER - 1);
      model_search(t, ef, eidx, eit, elat);
      run_req("EDGE_LAST", t, ef, eidx, eit, elat, 1'b1);
      t = lfsr_at(POLY0, MAX_ITER);
      model_search(t, ef, eidx, eit, elat);
      run_req("EDGE_PAST", t, ef, eidx, eit, elat, 1'b1);

      // T3: a target no entry reaches within MAX_ITER steps.
      t_miss = 17'h1ffff;
      for (int c = 0; c < 64; c++) begin
         model_search(t_miss, ef, eidx, eit, elat);
         if (!ef) break;
         t_miss = t_miss - 17'd1;
      end
      model_search(t_miss, ef, eidx, eit, elat);
      run_req("T3", t_miss, ef, eidx, eit, elat, 1'b1);

      // T5: reset in the middle of a search.
      req_valid  = 1'b1;
      req_target = lfsr_at(POLY0, 500);
      @(posedge clk_96MHz);
      #1;
      req_valid = 1'b0;
      repeat (100) @(posedge clk_96MHz);
      #1;
      check("T5_running", 32'(lfsr_enable), 32'd1);
      reset = 1'b1;
      @(posedge clk_96MHz);
      #1;
      reset = 1'b0;
      check("T5_ready", 32'(req_ready), 32'd1);
      check("T5_enable", 32'(lfsr_enable), 32'd0);
      check("T5_valid", 32'(res_valid), 32'd0);
      check("T5_poly", 32'(lfsr_polynomial), 32'(POLY0));
      $display("txn T5 reset during RUN");
      t = lfsr_at(POLY1, 37);
      model_search(t, ef, eidx, eit, elat);
      run_req("T5b", t, ef, eidx, eit, elat, 1'b1);

`ifdef LFSR_SEARCH_ABORT_EN
      // T6: abort on RUN cycle 50 of a search that would otherwise exhaust.
      req_valid  = 1'b1;
      req_target = t_miss;
      @(posedge clk_96MHz);
      #1;
      req_valid = 1'b0;
      @(posedge clk_96MHz);
      #1;
      repeat (50) @(posedge clk_96MHz);
      #1;
      check("T6_running", 32'(lfsr_enable), 32'd1);
      abort = 1'b1;
      @(posedge clk_96MHz);
      #1;
      abort = 1'b0;
      check("T6_valid", 32'(res_valid), 32'd1);
      check("T6_found", 32'(res_found), 32'd0);
      check("T6_idx", 32'(res_poly_idx), 32'd0);
      check("T6_iter", 32'(res_iter), 32'd0);
      check("T6_enable", 32'(lfsr_enable), 32'd0);
      $display("txn T6 abort at RUN cycle 50 found=%0d", res_found);
      res_ready = 1'b1;
      @(posedge clk_96MHz);
      #1;
      res_ready = 1'b0;
      check("T6_valid_drop", 32'(res_valid), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
